// File: rtl/ser_des_pkg.sv
// Shared word/beat geometry and FSM encoding for the 40-bit <-> 13-bit serdes pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a; consumers apply their own load/ready handshake.
package ser_des_pkg;

    localparam int WORD_W = 40;
    localparam int BEAT_W = 13;
    localparam int BEATS  = 4;
    localparam int CNT_W  = 2;

    // Beat index of the final beat in a frame
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Word bit ranges carried by each beat; beat3 carries a single bit in Dout[0]
    localparam int BEAT0_LO = 0;
    localparam int BEAT0_HI = 12;
    localparam int BEAT1_LO = 13;
    localparam int BEAT1_HI = 25;
    localparam int BEAT2_LO = 26;
    localparam int BEAT2_HI = 38;
    localparam int BEAT3_LO = 39;
    localparam int BEAT3_HI = 39;
    localparam int BEAT3_W  = BEAT3_HI - BEAT3_LO + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/ser40x13.sv
// 40-bit to 13-bit serializer, double buffered (hold + frame), 4 beats per word.
// Latency: Ld capture edge to first beat is one edge; back-to-back frames have no gap.
// Backpressure: Rdy = !hold_full; Ld while Rdy=0 is dropped. Optional Par under SER40X13_PARITY_EN.
module ser40x13
    import ser_des_pkg::*;
(
    input  logic              Cin,
    input  logic              Rst,
    input  logic [WORD_W-1:0] Din,
    input  logic              Ld,
    output logic              Rdy,
    output logic [BEAT_W-1:0] Dout,
    output logic              Vld,
    output logic              Sof,
    output logic [CNT_W-1:0]  cnt
`ifdef SER40X13_PARITY_EN
    ,
    output logic              Par
`endif
);

    state_t              state;
    logic [WORD_W-1:0]   hold;
    logic                hold_full;
    logic [WORD_W-1:0]   frame;

    logic                last_beat;
    logic                transfer;
    logic                take;
    logic [WORD_W-1:0]   mux_word;
    logic [CNT_W-1:0]    mux_idx;
    logic [BEAT_W-1:0]   mux_beat;

    assign Rdy       = ~hold_full;
    assign last_beat = (cnt == LAST_BEAT);
    // hold moves to frame when the serializer is idle or finishing the last beat
    assign transfer  = hold_full && ((state == IDLE) || last_beat);
    // a transfer edge always has hold_full=1, so take and transfer never coincide
    assign take      = Ld && !hold_full;

    // Select the word and beat index driven next, then slice out that beat
    always_comb begin
        mux_word = frame;
        mux_idx  = cnt + 1'b1;
        mux_beat = '0;
        if (transfer) begin
            mux_word = hold;
            mux_idx  = '0;
        end
        case (mux_idx)
            2'd0:    mux_beat = mux_word[BEAT0_HI:BEAT0_LO];
            2'd1:    mux_beat = mux_word[BEAT1_HI:BEAT1_LO];
            2'd2:    mux_beat = mux_word[BEAT2_HI:BEAT2_LO];
            default: mux_beat = {{(BEAT_W - BEAT3_W){1'b0}}, mux_word[BEAT3_HI:BEAT3_LO]};
        endcase
    end

    // Holding buffer: emptied by a transfer, filled by an accepted load
    always_ff @(posedge Cin or posedge Rst) begin
        if (Rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (transfer) begin
            hold_full <= 1'b0;
        end else if (take) begin
            hold      <= Din;
            hold_full <= 1'b1;
        end
    end

    // Frame FSM with registered beat outputs
    always_ff @(posedge Cin or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            frame <= '0;
            Dout  <= '0;
            Vld   <= 1'b0;
            Sof   <= 1'b0;
            cnt   <= '0;
`ifdef SER40X13_PARITY_EN
            Par   <= 1'b0;
`endif
        end else if (transfer) begin
            // start a new frame, either from idle or straight after the last beat
            state <= SEND;
            frame <= hold;
            Dout  <= mux_beat;
            Vld   <= 1'b1;
            Sof   <= 1'b1;
            cnt   <= '0;
`ifdef SER40X13_PARITY_EN
            Par   <= ^mux_beat;
`endif
        end else if (state == SEND) begin
            if (!last_beat) begin
                Dout <= mux_beat;
                Sof  <= 1'b0;
                cnt  <= mux_idx;
`ifdef SER40X13_PARITY_EN
                Par  <= ^mux_beat;
`endif
            end else begin
                // last beat sent and nothing waiting: go quiet
                state <= IDLE;
                Dout  <= '0;
                Vld   <= 1'b0;
                Sof   <= 1'b0;
                cnt   <= '0;
`ifdef SER40X13_PARITY_EN
                Par   <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ser40x13.sv
module tb_ser40x13;

    typedef struct {
        logic [12:0] dout;
        logic        sof;
        logic [1:0]  idx;
    } beat_t;

    logic        Cin;
    logic        Rst;
    logic [39:0] Din;
    logic        Ld;
    logic        Rdy;
    logic [12:0] Dout;
    logic        Vld;
    logic        Sof;
    logic [1:0]  cnt;
`ifdef SER40X13_PARITY_EN
    logic        Par;
`endif

    int checks   = 0;
    int failures = 0;

    beat_t       beat_q[$];
    logic [39:0] word_q[$];
    logic [39:0] acc;

    ser40x13 dut (
        .Cin  (Cin),
        .Rst  (Rst),
        .Din  (Din),
        .Ld   (Ld),
        .Rdy  (Rdy),
        .Dout (Dout),
        .Vld  (Vld),
        .Sof  (Sof),
        .cnt  (cnt)
`ifdef SER40X13_PARITY_EN
        ,
        .Par  (Par)
`endif
    );

    initial begin
        Cin = 1'b0;
        forever #5 Cin = ~Cin;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Expected beats of a word, derived straight from the beat layout
    task automatic push_word(input logic [39:0] w);
        beat_t b;
        b.dout = w[12:0];            b.sof = 1'b1; b.idx = 2'd0; beat_q.push_back(b);
        b.dout = w[25:13];           b.sof = 1'b0; b.idx = 2'd1; beat_q.push_back(b);
        b.dout = w[38:26];           b.sof = 1'b0; b.idx = 2'd2; beat_q.push_back(b);
        b.dout = {12'b0, w[39]};     b.sof = 1'b0; b.idx = 2'd3; beat_q.push_back(b);
        word_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge Cin);
        #1;
    endtask

    task automatic load(input logic [39:0] w);
        int n;
        n = 0;
        while (Rdy !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (Rdy !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL load_wait: Rdy=%b required 1 within 50 cycles", Rdy);
        end
        Din = w;
        Ld  = 1'b1;
        tick();
        Ld  = 1'b0;
        push_word(w);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((beat_q.size() != 0 || Vld !== 1'b0) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (beat_q.size() != 0 || Vld !== 1'b0) begin
            failures++;
            $display("FAIL %s drain: pending=%0d Vld=%b required 0 and 0", name, beat_q.size(), Vld);
        end
    endtask

    // Scoreboard monitor plus a 13-to-40 reassembler, sampled on the falling edge
    always @(negedge Cin) begin
        if (Rst === 1'b0) begin
            checks++;
            if (Vld === 1'b1) begin
                if (beat_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected: Dout=%h cnt=%0d required no beat", Dout, cnt);
                end else begin
                    beat_t e;
                    e = beat_q.pop_front();
                    if (Dout !== e.dout || Sof !== e.sof || cnt !== e.idx) begin
                        failures++;
                        $display("FAIL beat: Dout=%h Sof=%b cnt=%0d required Dout=%h Sof=%b cnt=%0d",
                                 Dout, Sof, cnt, e.dout, e.sof, e.idx);
                    end
                end
                case (cnt)
                    2'd0: acc[12:0]  = Dout;
                    2'd1: acc[25:13] = Dout;
                    2'd2: acc[38:26] = Dout;
                    default: begin
                        acc[39] = Dout[0];
                        checks++;
                        if (word_q.size() == 0) begin
                            failures++;
                            $display("FAIL loopback: got word %h required none", acc);
                        end else begin
                            logic [39:0] ew;
                            ew = word_q.pop_front();
                            if (acc !== ew) begin
                                failures++;
                                $display("FAIL loopback: got word %h required %h", acc, ew);
                            end
                        end
                    end
                endcase
            end else if (Dout !== 13'h0 || Sof !== 1'b0) begin
                failures++;
                $display("FAIL idle_out: Dout=%h Sof=%b required 0 and 0", Dout, Sof);
            end
`ifdef SER40X13_PARITY_EN
            checks++;
            if (Par !== (Vld === 1'b1 ? ^Dout : 1'b0)) begin
                failures++;
                $display("FAIL parity: Par=%b Vld=%b Dout=%h required %b", Par, Vld, Dout,
                         (Vld === 1'b1 ? ^Dout : 1'b0));
            end
`endif
        end
    end

    task automatic test_reset();
        Rst = 1'b1;
        Ld  = 1'b0;
        Din = '0;
        tick();
        tick();
        checks++; if (Vld !== 1'b0)   begin failures++; $display("FAIL reset_vld: %b required 0", Vld); end
        checks++; if (Dout !== 13'h0) begin failures++; $display("FAIL reset_dout: %h required 0", Dout); end
        checks++; if (Sof !== 1'b0)   begin failures++; $display("FAIL reset_sof: %b required 0", Sof); end
        checks++; if (cnt !== 2'd0)   begin failures++; $display("FAIL reset_cnt: %0d required 0", cnt); end
        checks++; if (Rdy !== 1'b1)   begin failures++; $display("FAIL reset_rdy: %b required 1", Rdy); end
`ifdef SER40X13_PARITY_EN
        checks++; if (Par !== 1'b0)   begin failures++; $display("FAIL reset_par: %b required 0", Par); end
`endif
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        load(40'hA512345678);
        checks++; if (Vld !== 1'b0) begin failures++; $display("FAIL single_lat_vld: %b required 0", Vld); end
        checks++; if (Rdy !== 1'b0) begin failures++; $display("FAIL single_rdy_held: %b required 0", Rdy); end
        tick();
        checks++; if (Vld !== 1'b1 || Dout !== 13'h1678 || Sof !== 1'b1 || cnt !== 2'd0) begin
            failures++; $display("FAIL single_b0: Vld=%b Dout=%h Sof=%b cnt=%0d required 1 1678 1 0", Vld, Dout, Sof, cnt); end
        checks++; if (Rdy !== 1'b1) begin failures++; $display("FAIL single_rdy_free: %b required 1", Rdy); end
        tick();
        checks++; if (Dout !== 13'h11A2 || Sof !== 1'b0 || cnt !== 2'd1) begin
            failures++; $display("FAIL single_b1: Dout=%h Sof=%b cnt=%0d required 11a2 0 1", Dout, Sof, cnt); end
        tick();
        checks++; if (Dout !== 13'h0944 || cnt !== 2'd2) begin
            failures++; $display("FAIL single_b2: Dout=%h cnt=%0d required 0944 2", Dout, cnt); end
        tick();
        checks++; if (Dout !== 13'h0001 || cnt !== 2'd3 || Vld !== 1'b1) begin
            failures++; $display("FAIL single_b3: Dout=%h cnt=%0d Vld=%b required 0001 3 1", Dout, cnt, Vld); end
        tick();
        checks++; if (Vld !== 1'b0 || Dout !== 13'h0) begin
            failures++; $display("FAIL single_end: Vld=%b Dout=%h required 0 0", Vld, Dout); end
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        load(40'hA512345678);
        tick();
        tick();
        load(40'h00000FFFFF);
        checks++; if (Dout !== 13'h0944 || Rdy !== 1'b0) begin
            failures++; $display("FAIL b2b_hold: Dout=%h Rdy=%b required 0944 0", Dout, Rdy); end
        tick();
        checks++; if (Dout !== 13'h0001 || cnt !== 2'd3) begin
            failures++; $display("FAIL b2b_last: Dout=%h cnt=%0d required 0001 3", Dout, cnt); end
        tick();
        checks++; if (Vld !== 1'b1 || Sof !== 1'b1 || Dout !== 13'h1FFF || Rdy !== 1'b1) begin
            failures++; $display("FAIL b2b_gap: Vld=%b Sof=%b Dout=%h Rdy=%b required 1 1 1fff 1", Vld, Sof, Dout, Rdy); end
        tick();
        checks++; if (Dout !== 13'h007F || cnt !== 2'd1) begin
            failures++; $display("FAIL b2b_b1: Dout=%h cnt=%0d required 007f 1", Dout, cnt); end
        wait_drain("back_to_back");
    endtask

    task automatic test_dropped();
        load(40'h123456789A);
        load(40'h0F0F0F0F0F);
        for (int i = 0; i < 2; i++) begin
            checks++; if (Rdy !== 1'b0) begin
                failures++; $display("FAIL dropped_rdy%0d: %b required 0", i, Rdy); end
            Din = 40'hDEADBEEF55;
            Ld  = 1'b1;
            tick();
            Ld  = 1'b0;
        end
        wait_drain("dropped");
    endtask

    task automatic test_reset_mid();
        int n;
        load(40'h5555AAAA33);
        load(40'h7777777777);
        n = 0;
        while (!(Vld === 1'b1 && cnt === 2'd2) && n < 20) begin
            tick();
            n++;
        end
        checks++; if (Vld !== 1'b1 || cnt !== 2'd2) begin
            failures++; $display("FAIL rstmid_reach: Vld=%b cnt=%0d required 1 2", Vld, cnt); end
        #2;
        Rst = 1'b1;
        #1;
        checks++; if (Vld !== 1'b0 || Dout !== 13'h0 || Rdy !== 1'b1 || Sof !== 1'b0 || cnt !== 2'd0) begin
            failures++; $display("FAIL rstmid_async: Vld=%b Dout=%h Rdy=%b Sof=%b cnt=%0d required 0 0 1 0 0",
                                 Vld, Dout, Rdy, Sof, cnt); end
        beat_q.delete();
        word_q.delete();
        tick();
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (Vld !== 1'b0 || Rdy !== 1'b1) begin
                failures++; $display("FAIL rstmid_quiet%0d: Vld=%b Rdy=%b required 0 1", i, Vld, Rdy); end
        end
        load(40'h0123456789);
        tick();
        checks++; if (Vld !== 1'b1 || Dout !== 13'h0789) begin
            failures++; $display("FAIL rstmid_first: Vld=%b Dout=%h required 1 0789", Vld, Dout); end
        wait_drain("reset_mid");
    endtask

`ifdef SER40X13_PARITY_EN
    task automatic test_parity();
        load(40'hA512345678);
        tick();
        checks++; if (Dout !== 13'h1678 || Par !== 1'b1) begin
            failures++; $display("FAIL parity_b0: Dout=%h Par=%b required 1678 1", Dout, Par); end
        wait_drain("parity");
    endtask
`endif

    task automatic test_loopback();
        logic [39:0] w;
        for (int i = 0; i < 100; i++) begin
            w[31:0]  = $urandom();
            w[39:32] = 8'($urandom());
            load(w);
        end
        wait_drain("loopback");
        checks++; if (word_q.size() != 0) begin
            failures++; $display("FAIL loopback_left: %0d words required 0", word_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_dropped();
        test_reset_mid();
`ifdef SER40X13_PARITY_EN
        test_parity();
`endif
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
